// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared types, defaults and helpers for the wait-state data memory
package arm_mem_pkg;

    localparam int DEFAULT_WAIT_CYCLES = 2;
    localparam int DEFAULT_DEPTH       = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of word-index bits needed to address depth words
    function automatic int word_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dmem_wait_responder_if.sv
// rtl/dmem_wait_responder_if.sv - M-stage data memory bus between pipeline and responder
interface dmem_wait_responder_if;

    logic        MemReqM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        ReadyM;
    logic        MisalignM;

    modport master (
        output MemReqM, MemWriteM, ALUResultM, WriteDataM,
        input  ReadDataM, StallM, ReadyM, MisalignM
    );

    modport slave (
        input  MemReqM, MemWriteM, ALUResultM, WriteDataM,
        output ReadDataM, StallM, ReadyM, MisalignM
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage with synchronous write and registered synchronous read
module dmem_array
    import arm_mem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int IW    = word_idx_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [IW-1:0] idx_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Contents survive reset; only the read-data register is cleared
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - fixed-latency data memory that stalls the pipeline for WAIT_CYCLES
module dmem_wait_responder
    import arm_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int DEPTH       = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    dmem_wait_responder_if.slave  bus
);

    localparam int         IW       = word_idx_w(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;

    logic          access;
    logic          unused_addr_hi;

    // Address bits above the word index never reach storage, giving modulo-DEPTH wrap
    assign unused_addr_hi = ^bus.ALUResultM[31:IW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            IDLE: begin
                if (bus.MemReqM) begin
                    addr_d  = bus.ALUResultM[IW+1:0];
                    wdata_d = bus.WriteDataM;
                    write_d = bus.MemWriteM;
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            // A request still visible here belongs to the instruction just completed
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    assign access = (state_q == WAIT) && (cnt_q == 4'd0);

    dmem_array #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (access && write_q),
        .re_i    (access && !write_q),
        .idx_i   (addr_q[IW+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (bus.ReadDataM)
    );

    // Stall is raised combinationally on the request cycle so the pipeline freezes at once
    assign bus.StallM    = (state_q == WAIT) || ((state_q == IDLE) && bus.MemReqM && reset);
    assign bus.ReadyM    = (state_q == DONE);
    assign bus.MisalignM = (state_q == DONE) && (addr_q[1:0] != 2'b00);

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - self-checking bench for dmem_wait_responder
module tb_dmem_wait_responder;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic [31:0] ref_mem [64];
    logic [31:0] ref_rd;
    int          last_ready_cyc;

    dmem_wait_responder_if bus0();
    dmem_wait_responder_if bus1();
    dmem_wait_responder_if bus2();

    dmem_wait_responder #(.WAIT_CYCLES(2),  .DEPTH(64)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_wait_responder #(.WAIT_CYCLES(1),  .DEPTH(64)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_wait_responder #(.WAIT_CYCLES(15), .DEPTH(64)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One access on dut0: start in IDLE at posedge+1, check timing, flags and data
    task automatic access0(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic keep);
        int          stall_n  = 0;
        int          ready_at = -1;
        int          idx;
        logic [31:0] exp_rd;
        idx    = int'(addr[7:2]);
        exp_rd = wr ? ref_rd : ref_mem[idx];
        bus0.MemReqM    = 1'b1;
        bus0.MemWriteM  = wr;
        bus0.ALUResultM = addr;
        bus0.WriteDataM = data;
        for (int c = 0; c < 40 && ready_at < 0; c++) begin
            @(negedge clk);
            if (bus0.StallM) stall_n++;
            if (bus0.ReadyM) begin
                ready_at       = c;
                last_ready_cyc = cyc;
                n_checks++;
                if (bus0.StallM !== 1'b0) begin
                    n_fail++;
                    $display("FAIL stall_in_done addr=%h got=%b want=0", addr, bus0.StallM);
                end
                n_checks++;
                if (bus0.MisalignM !== (addr[1:0] != 2'b00)) begin
                    n_fail++;
                    $display("FAIL misalign addr=%h got=%b want=%b", addr, bus0.MisalignM,
                             addr[1:0] != 2'b00);
                end
                n_checks++;
                if (bus0.ReadDataM !== exp_rd) begin
                    n_fail++;
                    $display("FAIL read_data wr=%b addr=%h got=%h want=%h", wr, addr,
                             bus0.ReadDataM, exp_rd);
                end
            end
            @(posedge clk);
            #1;
        end
        if (!keep) bus0.MemReqM = 1'b0;
        n_checks++;
        if (ready_at !== 3) begin
            n_fail++;
            $display("FAIL ready_latency addr=%h got=%0d want=3", addr, ready_at);
        end
        n_checks++;
        if (stall_n !== 3) begin
            n_fail++;
            $display("FAIL stall_cycles addr=%h got=%0d want=3", addr, stall_n);
        end
        if (wr) ref_mem[idx] = data;
        else    ref_rd       = ref_mem[idx];
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus0.MemReqM = 1'b1;
        cycle();
        cycle();
        @(negedge clk);
        n_checks++;
        if (bus0.StallM !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall got=%b want=0", bus0.StallM);
        end
        n_checks++;
        if (bus0.ReadyM !== 1'b0) begin
            n_fail++; $display("FAIL reset_ready got=%b want=0", bus0.ReadyM);
        end
        n_checks++;
        if (bus0.MisalignM !== 1'b0) begin
            n_fail++; $display("FAIL reset_misalign got=%b want=0", bus0.MisalignM);
        end
        n_checks++;
        if (bus0.ReadDataM !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h want=0", bus0.ReadDataM);
        end
        @(posedge clk);
        #1;
        bus0.MemReqM = 1'b0;
        reset = 1'b1;
        cycle();
        ref_rd = 32'h0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 64; i++) access0(1'b1, 32'(i * 4), $urandom, 1'b0);
    endtask

    task automatic test_store_load();
        access0(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        access0(1'b0, 32'h10, 32'h0, 1'b0);
        n_checks++;
        if (bus0.ReadDataM !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL store_load got=%h want=deadbeef", bus0.ReadDataM);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        d = $urandom;
        access0(1'b1, 32'h104, d, 1'b0);
        access0(1'b0, 32'h004, 32'h0, 1'b0);
        n_checks++;
        if (bus0.ReadDataM !== d) begin
            n_fail++; $display("FAIL wrap got=%h want=%h", bus0.ReadDataM, d);
        end
    endtask

    task automatic test_misalign();
        access0(1'b0, 32'h13, 32'h0, 1'b0);
        access0(1'b1, 32'h22, $urandom, 1'b0);
    endtask

    task automatic test_back_to_back();
        int first_ready;
        int extra = 0;
        access0(1'b0, 32'h40, 32'h0, 1'b1);
        first_ready = last_ready_cyc;
        access0(1'b0, 32'h44, 32'h0, 1'b0);
        n_checks++;
        if (last_ready_cyc - first_ready !== 4) begin
            n_fail++;
            $display("FAIL b2b_spacing got=%0d want=4", last_ready_cyc - first_ready);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus0.ReadyM || bus0.StallM) extra++;
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (extra !== 0) begin
            n_fail++; $display("FAIL b2b_third_access got=%0d want=0", extra);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] prior;
        prior = ref_mem[8];
        bus0.MemReqM    = 1'b1;
        bus0.MemWriteM  = 1'b1;
        bus0.ALUResultM = 32'h20;
        bus0.WriteDataM = 32'h55;
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus0.StallM !== 1'b0) begin
            n_fail++; $display("FAIL abort_stall got=%b want=0", bus0.StallM);
        end
        bus0.MemReqM = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycle();
        ref_rd = 32'h0;
        n_checks++;
        if (bus0.ReadDataM !== 32'h0) begin
            n_fail++; $display("FAIL abort_rdata got=%h want=0", bus0.ReadDataM);
        end
        access0(1'b0, 32'h20, 32'h0, 1'b0);
        n_checks++;
        if (bus0.ReadDataM !== prior) begin
            n_fail++; $display("FAIL abort_no_write got=%h want=%h", bus0.ReadDataM, prior);
        end
    endtask

    task automatic test_reset_pending();
        reset = 1'b0;
        cycle();
        ref_rd = 32'h0;
        reset = 1'b1;
        access0(1'b0, $urandom, 32'h0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            access0(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        bus0.MemReqM = 1'b0;
        cycle();
    endtask

    // Same store-then-load on the WAIT_CYCLES=1 and =15 instances in lockstep
    task automatic test_wait_sweep();
        logic [31:0] addr;
        logic [31:0] data;
        addr = {$urandom} & 32'hFC;
        data = $urandom;
        for (int op = 0; op < 2; op++) begin
            int s1 = 0, s2 = 0, r1 = -1, r2 = -1;
            logic [31:0] d1 = 32'h0, d2 = 32'h0;
            bus1.MemReqM = 1'b1; bus1.MemWriteM = (op == 0); bus1.ALUResultM = addr;
            bus1.WriteDataM = data;
            bus2.MemReqM = 1'b1; bus2.MemWriteM = (op == 0); bus2.ALUResultM = addr;
            bus2.WriteDataM = data;
            for (int c = 0; c < 40 && (r1 < 0 || r2 < 0); c++) begin
                @(negedge clk);
                if (r1 < 0) begin
                    if (bus1.StallM) s1++;
                    if (bus1.ReadyM) begin r1 = c; d1 = bus1.ReadDataM; end
                end
                if (r2 < 0) begin
                    if (bus2.StallM) s2++;
                    if (bus2.ReadyM) begin r2 = c; d2 = bus2.ReadDataM; end
                end
                @(posedge clk);
                #1;
                if (r1 >= 0) bus1.MemReqM = 1'b0;
                if (r2 >= 0) bus2.MemReqM = 1'b0;
            end
            bus1.MemReqM = 1'b0;
            bus2.MemReqM = 1'b0;
            n_checks++;
            if (s1 !== 2 || r1 !== 2) begin
                n_fail++; $display("FAIL sweep_w1 op=%0d stall=%0d ready=%0d want=2/2", op, s1, r1);
            end
            n_checks++;
            if (s2 !== 16 || r2 !== 16) begin
                n_fail++;
                $display("FAIL sweep_w15 op=%0d stall=%0d ready=%0d want=16/16", op, s2, r2);
            end
            if (op == 1) begin
                n_checks++;
                if (d1 !== data || d2 !== data) begin
                    n_fail++;
                    $display("FAIL sweep_data got=%h/%h want=%h", d1, d2, data);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ref_rd   = 32'h0;
        last_ready_cyc = 0;
        reset = 1'b0;
        bus0.MemReqM = 1'b0; bus0.MemWriteM = 1'b0; bus0.ALUResultM = '0; bus0.WriteDataM = '0;
        bus1.MemReqM = 1'b0; bus1.MemWriteM = 1'b0; bus1.ALUResultM = '0; bus1.WriteDataM = '0;
        bus2.MemReqM = 1'b0; bus2.MemWriteM = 1'b0; bus2.ALUResultM = '0; bus2.WriteDataM = '0;
        test_reset();
        test_fill();
        test_store_load();
        test_wrap();
        test_misalign();
        test_back_to_back();
        test_reset_abort();
        test_reset_pending();
        test_random();
        test_wait_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
